fp_addsub_seq: RTL and testbench

Parametrised, multi-cycle IEEE-754 adder/subtractor and the successor to the single-cycle floating-point add/sub datapath. It accepts one operand pair through a valid/ready handshake, then aligns, adds, normalises and rounds over successive cycles under an internal FSM. Results use round-to-nearest-even with a 3-bit guard/round/sticky extension. It sits between the FP register-file read stage and writeback and exposes exception flags.

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_round_rne.sv | 23 ++
 rtl/fp_addsub_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM states, flag bit positions and special-value constructors for the FP units
package fp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;
  localparam int FP_MAX_W = 128;
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] one = FP_MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction
  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] one = FP_MAX_W'(1);
    return (FP_MAX_W'(sign) << (exp_w + man_w)) | (((one << exp_w) - one) << man_w);
  endfunction
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round a hidden+fraction+GRS frame to nearest-even, reporting exponent overflow and inexact
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+3:0] frame,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W-1:0] frac,
  output logic [EXP_W-1:0] exp_o,
  output logic             ovf,
  output logic             inexact
);
  logic             inc;
  logic [MAN_W+1:0] sum;
  logic [EXP_W:0]   exp_r;
  assign inc     = frame[2] && (frame[1] || frame[0] || frame[3]);
  assign sum     = {1'b0, frame[MAN_W+3:3]} + (MAN_W+2)'(inc);
  assign exp_r   = {1'b0, exp_i} + (EXP_W+1)'(sum[MAN_W+1]);
  assign frac    = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign exp_o   = exp_r[EXP_W-1:0];
  assign ovf     = exp_r >= {1'b0, {EXP_W{1'b1}}};
  assign inexact = |frame[2:0];
endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 add/subtract with RNE rounding, valid/ready handshake and exception flags
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] num_a,
  input  logic [EXP_W+MAN_W:0] num_b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + 4;
  localparam logic [EXP_W-1:0] EMAX = '1;
  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             sign_q, sign_d, sy_q, sy_d, sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [FW:0]      sum_q, sum_d;
  logic [FW-1:0]    y_q, y_d;
  logic [EXP_W-1:0] ea, eb, ex, ey, diff;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, swap, sx, sy;
  logic [FW-1:0]    fra, frb, fx, fy, y_sh;
  logic [W-1:0]     qnan;
  logic [MAN_W-1:0] rnd_frac;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_ovf, rnd_inx;
  assign ea    = a_q[W-2:MAN_W];
  assign eb    = b_q[W-2:MAN_W];
  assign fa    = a_q[MAN_W-1:0];
  assign fb    = b_q[MAN_W-1:0];
  assign a_nan = ea == EMAX && fa != '0;
  assign b_nan = eb == EMAX && fb != '0;
  assign a_inf = ea == EMAX && fa == '0;
  assign b_inf = eb == EMAX && fb == '0;
  assign fra   = ea == '0 ? '0 : {1'b1, fa, 3'b000};
  assign frb   = eb == '0 ? '0 : {1'b1, fb, 3'b000};
  assign swap  = {eb, frb} > {ea, fra};
  assign ex    = swap ? eb : ea;
  assign ey    = swap ? ea : eb;
  assign fx    = swap ? frb : fra;
  assign fy    = swap ? fra : frb;
  assign sx    = swap ? b_q[W-1] : a_q[W-1];
  assign sy    = swap ? a_q[W-1] : b_q[W-1];
  assign diff  = ex - ey;
  assign y_sh  = 32'(diff) >= FW ? FW'(|fy) : (fy >> diff) | FW'(|(fy & ~({FW{1'b1}} << diff)));
  assign qnan  = W'(fp_qnan(EXP_W, MAN_W));
  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .frame   (sum_q[FW-1:0]),
    .exp_i   (exp_q),
    .frac    (rnd_frac),
    .exp_o   (rnd_exp),
    .ovf     (rnd_ovf),
    .inexact (rnd_inx)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    sy_d     = sy_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    sum_d    = sum_q;
    y_d      = y_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready_q) begin
        a_d     = num_a;
        b_d     = {num_b[W-1] ^ op, num_b[W-2:0]};
        flags_d = '0;
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_DONE;
        if (a_nan || b_nan) result_d = qnan;
        else if (a_inf && b_inf && a_q[W-1] != b_q[W-1]) begin
          result_d         = qnan;
          flags_d[FLG_INV] = 1'b1;
        end
        else if (a_inf) result_d = a_q;
        else if (b_inf) result_d = b_q;
        else begin
          state_d = S_ADD;
          sign_d  = sx;
          sy_d    = sy;
          sub_d   = sx ^ sy;
          exp_d   = ex;
          sum_d   = {1'b0, fx};
          y_d     = y_sh;
        end
      end
      S_ADD: begin
        sum_d   = sub_q ? sum_q - {1'b0, y_q} : sum_q + {1'b0, y_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_ROUND;
        if (sum_q[FW]) begin
          sum_d = {1'b0, sum_q[FW:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + EXP_W'(1);
        end
        else if (sum_q[FW-1]) state_d = S_ROUND;
        else if (sum_q == '0) begin
          sign_d = sign_q & sy_q;
          exp_d  = '0;
        end
        else if (exp_q == EXP_W'(1)) begin
          sum_d            = '0;
          exp_d            = '0;
          flags_d[FLG_UNF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end
        else begin
          sum_d   = sum_q << 1;
          exp_d   = exp_q - EXP_W'(1);
          state_d = S_NORM;
        end
      end
      S_ROUND: begin
        result_d         = rnd_ovf ? W'(fp_inf(sign_q, EXP_W, MAN_W)) : {sign_q, rnd_exp, rnd_frac};
        flags_d[FLG_OVF] = flags_q[FLG_OVF] | rnd_ovf;
        flags_d[FLG_INX] = flags_q[FLG_INX] | rnd_inx | rnd_ovf;
        state_d          = S_DONE;
      end
      S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = state_d == S_IDLE;
    out_valid_d = state_q == S_DONE && state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
    a_q    <= a_d;
    b_q    <= b_d;
    sign_q <= sign_d;
    sy_q   <= sy_d;
    sub_q  <= sub_d;
    exp_q  <= exp_d;
    sum_q  <= sum_d;
    y_q    <= y_d;
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed-vector self-checking bench for fp_addsub_seq
module tb_fp_addsub_seq;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] num_a = '0, num_b = '0, result;
  logic [3:0]  flags;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_a     (num_a),
    .num_b     (num_b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    num_a    = a;
    num_b    = b;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic collect(input string tag, input logic [31:0] res, input logic [3:0] flg, input int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, result, res);
    check({tag, "_flg"}, 32'(flags), 32'(flg));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ovd"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 check("rdy_after_rst", 32'(in_ready), 32'd1);
    send(32'h3F800000, 32'h3F800000, 1'b0); collect("t1", 32'h40000000, 4'b0000, 5);
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1); collect("t2", 32'h33800000, 4'b0000, 29);
    send(32'h3F800000, 32'h33800000, 1'b0); collect("t3a", 32'h3F800000, 4'b0001, 5);
    send(32'h3F800001, 32'h33800000, 1'b0); collect("t3b", 32'h3F800002, 4'b0001, 5);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0); collect("t4a", 32'h7F800000, 4'b0101, 5);
    send(32'h7F800000, 32'hFF800000, 1'b0); collect("t4b", 32'h7FC00000, 4'b1000, 2);
    send(32'h40000000, 32'h3F800000, 1'b1); collect("sub1", 32'h3F800000, 4'b0000, 6);
    send(32'h3F800000, 32'hBF800000, 1'b0); collect("cancel", 32'h00000000, 4'b0000, 5);
    send(32'h80000000, 32'h80000000, 1'b0); collect("negzero", 32'h80000000, 4'b0000, 5);
    send(32'h00C00000, 32'h00800000, 1'b1); collect("unf", 32'h00000000, 4'b0011, 5);
    send(32'h00000001, 32'h3F800000, 1'b0); collect("denorm", 32'h3F800000, 4'b0000, 5);
    send(32'hFFA00000, 32'h3F800000, 1'b0); collect("nan_in", 32'h7FC00000, 4'b0000, 2);
    send(32'h7F800000, 32'h3F800000, 1'b0); collect("inf_fin", 32'h7F800000, 4'b0000, 2);
    send(32'h7F800000, 32'h7F800000, 1'b1); collect("inf_sub", 32'h7FC00000, 4'b1000, 2);
    send(32'h3F800000, 32'h3F800000, 1'b0);
    num_a    = 32'h3F800000;
    num_b    = 32'h33800000;
    op       = 1'b0;
    in_valid = 1'b1;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      check("t5_lat", 32'(n), 32'd5);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold_res", result, 32'h40000000);
      check("t5_hold_rdy", 32'(in_ready), 32'd0);
      check("t5_hold_ovd", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("t5_idle_ovd", 32'(out_valid), 32'd0);
    check("t5_idle_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t5_accepted", 32'(in_ready), 32'd0);
    collect("t5b", 32'h3F800000, 4'b0001, 5);
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ovd", 32'(out_valid), 32'd0);
    check("t6_rdy", 32'(in_ready), 32'd0);
    check("t6_res", result, 32'd0);
    check("t6_flg", 32'(flags), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1 check("t6_rdy_after", 32'(in_ready), 32'd1);
    check("t6_no_out", 32'(out_valid), 32'd0);
    send(32'h3F800000, 32'h3F800000, 1'b0); collect("t6_t1", 32'h40000000, 4'b0000, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
